// File: rtl/core_run_sequencer.sv
// Host run controller: turns a go pulse into a core req pulse, then times the run until ack or timeout.
// Define CORE_RUN_SEQ_STATS_EN to add run_count / min_cycles / max_cycles statistics outputs.
module core_run_sequencer #(
    parameter int                    CYCLE_BITS = 16,
    parameter int                    REQ_CYCLES = 2,
    parameter logic [CYCLE_BITS-1:0] TIMEOUT    = 16'hFFFF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  go,
    output logic                  req,
    input  logic                  ack,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CYCLE_BITS-1:0] cycles
`ifdef CORE_RUN_SEQ_STATS_EN
    ,
    output logic [15:0]           run_count,
    output logic [CYCLE_BITS-1:0] min_cycles,
    output logic [CYCLE_BITS-1:0] max_cycles
`endif
);

    // state  | meaning
    // IDLE   | after reset, waiting for go
    // LAUNCH | req held high for REQ_CYCLES cycles, ack ignored
    // RUN    | counting non-ack cycles until ack or timeout
    // DONE   | result and flags held until the next go

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_t;

    localparam int                REQ_W    = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
    localparam logic [REQ_W-1:0]  REQ_LAST = REQ_W'(REQ_CYCLES - 1);

    state_t                  state, state_nxt;
    logic [1:0]              rst_sync;
    logic [REQ_W-1:0]        req_cnt, req_cnt_nxt;
    logic [CYCLE_BITS-1:0]   run_cnt, run_cnt_nxt, cycles_nxt;
    logic                    req_nxt, busy_nxt, done_nxt, timeout_nxt;

    // Launches are blocked until the reset release has passed through both sync flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            req_cnt <= '0;
            run_cnt <= '0;
            cycles  <= '0;
            req     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            req_cnt <= req_cnt_nxt;
            run_cnt <= run_cnt_nxt;
            cycles  <= cycles_nxt;
            req     <= req_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            timeout <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_cnt_nxt = req_cnt;
        run_cnt_nxt = run_cnt;
        cycles_nxt  = cycles;
        req_nxt     = 1'b0;
        busy_nxt    = 1'b0;
        done_nxt    = done;
        timeout_nxt = timeout;
        case (state)
            S_IDLE, S_DONE: begin
                if (go && rst_sync[1]) begin
                    state_nxt   = S_LAUNCH;
                    req_cnt_nxt = '0;
                    cycles_nxt  = '0;
                    done_nxt    = 1'b0;
                    timeout_nxt = 1'b0;
                    req_nxt     = 1'b1;
                    busy_nxt    = 1'b1;
                end
            end
            S_LAUNCH: begin
                busy_nxt = 1'b1;
                if (req_cnt == REQ_LAST) begin
                    state_nxt   = S_RUN;
                    run_cnt_nxt = '0;
                end else begin
                    req_cnt_nxt = req_cnt + 1'b1;
                    req_nxt     = 1'b1;
                end
            end
            S_RUN: begin
                // Completion is checked first so a simultaneous ack beats the timeout.
                if (ack) begin
                    state_nxt  = S_DONE;
                    done_nxt   = 1'b1;
                    cycles_nxt = run_cnt;
                end else if (run_cnt == TIMEOUT) begin
                    state_nxt   = S_DONE;
                    timeout_nxt = 1'b1;
                    cycles_nxt  = TIMEOUT;
                end else begin
                    busy_nxt    = 1'b1;
                    run_cnt_nxt = run_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef CORE_RUN_SEQ_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_count  <= '0;
            min_cycles <= '1;
            max_cycles <= '0;
        end else if (state == S_RUN && ack) begin
            if (run_count != 16'hFFFF) begin
                run_count <= run_count + 1'b1;
            end
            if (run_cnt < min_cycles) begin
                min_cycles <= run_cnt;
            end
            if (run_cnt > max_cycles) begin
                max_cycles <= run_cnt;
            end
        end
    end
`else
    // Without statistics the sequencer carries no extra state.
`endif

endmodule

// File: doc/core_run_sequencer.md
# core_run_sequencer

Host-side run controller placed directly upstream of the processor top level: it converts a single-cycle host `go` pulse into the core's `req` start pulse, waits for the core's `ack` completion level, and measures run length in clock cycles. It also detects runaway programs with a cycle timeout and reports status to the host or testbench. A run is one program execution from PC reset to the done address.

## Interface
Parameters:
- `CYCLE_BITS`, 16: width of the run-length counter and `cycles` output.
- `REQ_CYCLES`, 2: number of cycles `req` is held high per launch; minimum 1.
- `TIMEOUT`, 16'hFFFF: abort threshold in run cycles; must be ≤ 2^CYCLE_BITS − 1.

Ports:
- `clock`  in  1: single system clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `go`  in  1: host launch request; sampled only in IDLE or DONE.
- `req`  out  1: start pulse to the core; the core resets its PC while this is high.
- `ack`  in  1: core done level; high while the core PC equals the done address.
- `busy`  out  1: high in LAUNCH and RUN.
- `done`  out  1: high in DONE after normal completion.
- `timeout`  out  1: high in DONE after a timeout abort.
- `cycles`  out  CYCLE_BITS: run length of the last completed run.

## Operation
- States: IDLE, LAUNCH, RUN, DONE.
- IDLE: `req`=0. `go`=1 → LAUNCH; `req_cnt` cleared; `cycles`, `done`, `timeout` cleared.
- LAUNCH: `req`=1 for exactly REQ_CYCLES cycles. `ack` is ignored, because the core may still be parked at the previous done address. After the last cycle → RUN; `run_cnt` is cleared.
- RUN: `req`=0. `run_cnt` increments each cycle in which `ack`=0.
  - `ack`=1 → DONE. Set `done`=1 and `cycles`=`run_cnt`, the count of cycles before `ack` rose.
  - `run_cnt`==TIMEOUT with `ack`=0 → DONE. Set `timeout`=1 and `cycles`=TIMEOUT.
  - If `ack`=1 and the timeout condition occur in the same cycle, completion wins: `done`=1, `timeout`=0.
- DONE: `cycles`, `done` and `timeout` hold. `go`=1 → LAUNCH, which clears the flags and `cycles` on entry. `go`=0 → stay in DONE.
- A `go` pulse during LAUNCH or RUN is ignored. It is not queued.
- The counter saturates and never wraps. TIMEOUT is the ceiling.

## Timing
- Reset values: state=IDLE, `req`=0, `busy`=0, `done`=0, `timeout`=0, `cycles`=0, internal counters 0.
- All outputs are registered. Nothing is combinational from `go` or `ack` to any output.
- `go` high at edge N → `req`=1 and `busy`=1 from edge N+1 through edge N+REQ_CYCLES; `req`=0 from edge N+REQ_CYCLES+1.
- In the first RUN cycle, `ack` is a legal completion. That run reports `cycles`=0.
- `ack` high at edge M in RUN → `done`=1 and `busy`=0 after edge M, i.e. 1-cycle latency.
- Reset asserted mid-run: all outputs clear immediately (asynchronously). `req` drops even mid-pulse. The next run requires a new `go`.
- Reset release is internally synchronised through a 2-flop deassertion sync. The FSM leaves IDLE no earlier than the second edge after `reset_n` rises.

## Configuration
- `CORE_RUN_SEQ_STATS_EN` defined:
  - Adds outputs `run_count` [15:0], `min_cycles` [CYCLE_BITS-1:0] and `max_cycles` [CYCLE_BITS-1:0].
  - All three update on each normal completion only; timeouts are excluded.
  - Reset values: `run_count`=0, `min_cycles`=all-ones, `max_cycles`=0.
  - `run_count` saturates at 16'hFFFF.
- `CORE_RUN_SEQ_STATS_EN` undefined: these ports and registers do not exist. Behaviour is otherwise identical.

## Test plan
- Basic run, REQ_CYCLES=2: `go` pulse at edge 10; core model raises `ack` 23 cycles after `req` falls → `req` high on edges 11–12, `done`=1, `cycles`=23, `busy`=0 one cycle after `ack`.
- Stale ack: hold `ack`=1 through LAUNCH, drop it on the first RUN cycle, raise it 5 cycles later → no early completion, `cycles`=5.
- Timeout, TIMEOUT=100: `ack` never rises → `timeout`=1, `done`=0, `cycles`=100. A following `go` clears both flags and relaunches.
- Tie and ignore: `ack` rises on the same cycle `run_cnt` hits TIMEOUT → `done`=1, `timeout`=0. Separately, a `go` pulse mid-RUN has no effect on `req` or `cycles`.
- Reset mid-LAUNCH: drop `reset_n` while `req`=1 → `req`, `busy` and `cycles` are 0 before the next edge; the FSM stays in IDLE until a new `go` after release plus 2 edges.
- Stats, with `CORE_RUN_SEQ_STATS_EN` defined: runs of 7, 3 and 12 cycles, then one timeout → `run_count`=3, `min_cycles`=3, `max_cycles`=12.
